// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions for the host transmit path and the keyboard receive path.
// Contents: transmitter state enumeration, frame geometry constants, the odd-parity
// helper and the default line timing (cycles at 50 MHz).
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_RTS,
    ST_SEND,
    ST_ACK,
    ST_WAIT_IDLE,
    ST_ERROR
  } ps2_state_e;

  localparam int DATA_BITS   = 8;
  localparam int FRAME_FALLS = 11;
  // data bits plus parity, shifted out one per device clock fall
  localparam int SHIFT_BITS  = DATA_BITS + 1;

  localparam int DEF_INHIBIT_CYCLES   = 6000;
  localparam int DEF_RTS_SETUP_CYCLES = 16;
  localparam int DEF_FILTER_LEN       = 8;
  localparam int DEF_TIMEOUT_CYCLES   = 1_000_000;

  function automatic logic odd_parity(input logic [DATA_BITS-1:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Conditioning for one open-drain PS/2 pin: 2-FF synchronizer, run-length glitch
// filter and a registered falling-edge strobe on the filtered level.
// Ports:
//   CLOCK_50  system clock
//   reset     synchronous, active-high; filtered level returns to 1 (idle line)
//   line_in   raw pin level (asynchronous)
//   level     filtered line level
//   fall      one-cycle strobe, high in the cycle level becomes 0
module ps2_line_filter
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = DEF_FILTER_LEN
) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic line_in,
  output logic level,
  output logic fall
);

  localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CNT_W-1:0] RUN_LOAD = CNT_W'(FILTER_LEN - 1);

  logic             sync_0;
  logic             sync_1;
  logic [CNT_W-1:0] run_cnt;

  // run_cnt counts down the remaining disagreeing samples needed; any sample that
  // agrees with the current level reloads it, so only an unbroken run switches.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      sync_0  <= 1'b1;
      sync_1  <= 1'b1;
      level   <= 1'b1;
      run_cnt <= RUN_LOAD;
      fall    <= 1'b0;
    end else begin
      sync_0 <= line_in;
      sync_1 <= sync_0;
      fall   <= 1'b0;
      if (sync_1 == level) begin
        run_cnt <= RUN_LOAD;
      end else if (run_cnt == '0) begin
        level   <= sync_1;
        run_cnt <= RUN_LOAD;
        fall    <= ~sync_1;
      end else begin
        run_cnt <= run_cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: clock inhibit, request-to-send, shifts data,
// odd parity and stop on device clock falls, then checks the device ACK bit.
// Ports:
//   CLOCK_50, reset           system clock, synchronous active-high reset
//   tx_valid, tx_data         command byte request, accepted when tx_ready
//   tx_ready                  high only in IDLE
//   busy                      high whenever a transfer is in progress
//   tx_done, tx_error         one-cycle completion pulses (ACK / NACK or timeout)
//   ps2_clk_in, ps2_dat_in    raw pin levels
//   ps2_clk_oe, ps2_dat_oe    1 = pull the pin low, 0 = release to the pull-up
//
// state        | meaning
// ST_IDLE      | lines released, waiting for tx_valid
// ST_INHIBIT   | clock held low, data released
// ST_RTS       | clock and data held low (start bit), setup before clock release
// ST_SEND      | clock released; next bit presented after each device clock fall
// ST_ACK       | waiting for the 11th fall to sample the device ACK
// ST_WAIT_IDLE | ACK seen, waiting for both filtered lines to return high
// ST_ERROR     | NACK or timeout; lines released, tx_error pulsed
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES   = DEF_INHIBIT_CYCLES,
  parameter int RTS_SETUP_CYCLES = DEF_RTS_SETUP_CYCLES,
  parameter int FILTER_LEN       = DEF_FILTER_LEN,
  parameter int TIMEOUT_CYCLES   = DEF_TIMEOUT_CYCLES
) (
  input  logic                 CLOCK_50,
  input  logic                 reset,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 busy,
  output logic                 tx_done,
  output logic                 tx_error,
  input  logic                 ps2_clk_in,
  input  logic                 ps2_dat_in,
  output logic                 ps2_clk_oe,
  output logic                 ps2_dat_oe
);

  localparam int PHASE_MAX = (INHIBIT_CYCLES > RTS_SETUP_CYCLES) ? INHIBIT_CYCLES
                                                                 : RTS_SETUP_CYCLES;
  localparam int PHASE_W   = $clog2(PHASE_MAX + 1);
  localparam int TO_W      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [3:0] LAST_SHIFT_FALL = 4'(SHIFT_BITS);

  ps2_state_e            state, state_next;
  logic [PHASE_W-1:0]    phase_cnt, phase_next;
  logic [TO_W-1:0]       to_cnt, to_next;
  logic [3:0]            bit_cnt, bit_next;
  logic [SHIFT_BITS-1:0] shift_q, shift_next;
  logic                  clk_oe_next, dat_oe_next;

  logic clk_level, clk_fall;
  logic dat_level, dat_fall_unused;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .line_in  (ps2_clk_in),
    .level    (clk_level),
    .fall     (clk_fall)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filter (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .line_in  (ps2_dat_in),
    .level    (dat_level),
    .fall     (dat_fall_unused)
  );

  assign tx_ready = (state == ST_IDLE);
  assign busy     = ~tx_ready;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state      <= ST_IDLE;
      phase_cnt  <= '0;
      to_cnt     <= '0;
      bit_cnt    <= '0;
      shift_q    <= '0;
      ps2_clk_oe <= 1'b0;
      ps2_dat_oe <= 1'b0;
    end else begin
      state      <= state_next;
      phase_cnt  <= phase_next;
      to_cnt     <= to_next;
      bit_cnt    <= bit_next;
      shift_q    <= shift_next;
      ps2_clk_oe <= clk_oe_next;
      ps2_dat_oe <= dat_oe_next;
    end
  end

  always_comb begin
    state_next  = state;
    phase_next  = phase_cnt;
    to_next     = to_cnt;
    bit_next    = bit_cnt;
    shift_next  = shift_q;
    dat_oe_next = ps2_dat_oe;
    tx_done     = 1'b0;
    tx_error    = 1'b0;

    case (state)
      ST_IDLE: begin
        dat_oe_next = 1'b0;
        if (tx_valid) begin
          state_next = ST_INHIBIT;
          shift_next = {odd_parity(tx_data), tx_data};
          phase_next = PHASE_W'(INHIBIT_CYCLES - 1);
        end
      end

      ST_INHIBIT: begin
        if (phase_cnt == '0) begin
          state_next  = ST_RTS;
          phase_next  = PHASE_W'(RTS_SETUP_CYCLES - 1);
          dat_oe_next = 1'b1;
        end else begin
          phase_next = phase_cnt - 1'b1;
        end
      end

      ST_RTS: begin
        if (phase_cnt == '0) begin
          state_next = ST_SEND;
          bit_next   = '0;
          to_next    = TO_W'(TIMEOUT_CYCLES - 1);
        end else begin
          phase_next = phase_cnt - 1'b1;
        end
      end

      ST_SEND: begin
        if (to_cnt == '0) begin
          state_next  = ST_ERROR;
          dat_oe_next = 1'b0;
        end else begin
          to_next = to_cnt - 1'b1;
          if (clk_fall) begin
            bit_next = bit_cnt + 4'd1;
            // falls 1..9 present data LSB first then parity; fall 10 releases for stop
            if (bit_cnt < LAST_SHIFT_FALL) begin
              dat_oe_next = ~shift_q[0];
              shift_next  = shift_q >> 1;
            end else begin
              dat_oe_next = 1'b0;
              state_next  = ST_ACK;
            end
          end
        end
      end

      ST_ACK: begin
        if (to_cnt == '0) begin
          state_next = ST_ERROR;
        end else begin
          to_next = to_cnt - 1'b1;
          if (clk_fall) begin
            state_next = dat_level ? ST_ERROR : ST_WAIT_IDLE;
          end
        end
      end

      ST_WAIT_IDLE: begin
        if (to_cnt == '0) begin
          state_next = ST_ERROR;
        end else begin
          to_next = to_cnt - 1'b1;
          if (clk_level && dat_level) begin
            tx_done    = 1'b1;
            state_next = ST_IDLE;
          end
        end
      end

      ST_ERROR: begin
        tx_error    = 1'b1;
        dat_oe_next = 1'b0;
        state_next  = ST_IDLE;
      end

      default: begin
        dat_oe_next = 1'b0;
        state_next  = ST_IDLE;
      end
    endcase

    clk_oe_next = (state_next == ST_INHIBIT) || (state_next == ST_RTS);
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
`timescale 1ns/1ps
module tb_ps2_host_tx;

  localparam int INH  = 300;
  localparam int RTS  = 16;
  localparam int FILT = 8;
  localparam int TOUT = 4000;

  logic       CLOCK_50 = 1'b0;
  logic       reset    = 1'b1;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data  = 8'h00;
  logic       tx_ready, busy, tx_done, tx_error, ps2_clk_oe, ps2_dat_oe;
  logic       ps2_clk_in, ps2_dat_in;
  logic       dev_clk_low = 1'b0;
  logic       dev_dat_low = 1'b0;

  // open-drain bus: either side pulling low wins
  assign ps2_clk_in = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_dat_in = ~(ps2_dat_oe | dev_dat_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES   (INH),
    .RTS_SETUP_CYCLES (RTS),
    .FILTER_LEN       (FILT),
    .TIMEOUT_CYCLES   (TOUT)
  ) dut (
    .CLOCK_50   (CLOCK_50),
    .reset      (reset),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_ready   (tx_ready),
    .busy       (busy),
    .tx_done    (tx_done),
    .tx_error   (tx_error),
    .ps2_clk_in (ps2_clk_in),
    .ps2_dat_in (ps2_dat_in),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_dat_oe (ps2_dat_oe)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int checks   = 0;
  int errors   = 0;
  int done_cnt = 0;
  int err_cnt  = 0;

  always @(negedge CLOCK_50) begin
    if (tx_done) done_cnt++;
    if (tx_error) err_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // odd parity: total number of ones over data plus parity must be odd
  function automatic logic ref_parity(input logic [7:0] b);
    return ($countones(b) % 2) == 0;
  endfunction

  task automatic start_request(input logic [7:0] b);
    int n, hi, hi_rel;
    n = 0;
    while (!tx_ready && n < 2000) begin
      @(negedge CLOCK_50);
      n++;
    end
    check_eq("ready_before_send", 32'(tx_ready), 32'd1);
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge CLOCK_50);
    tx_valid = 1'b0;
    hi = 0;
    hi_rel = 0;
    n = 0;
    while (ps2_clk_oe && n < INH + RTS + 100) begin
      if (!ps2_dat_oe) hi_rel++;
      hi++;
      n++;
      @(negedge CLOCK_50);
    end
    check_eq("clk_inhibit_cycles", 32'(hi), 32'(INH + RTS));
    check_eq("rts_overlap_cycles", 32'(hi - hi_rel), 32'(RTS));
    check_eq("start_bit_held", 32'(ps2_dat_oe), 32'd1);
  endtask

  // Device clocks falls 1..10, sampling host data at each rising edge; with nack=0
  // it pulls data low for the ACK after sampling the stop bit. Returns just before
  // fall 11, or mid-low of fall abort_fall when that is nonzero.
  task automatic dev_frame(input int half, input bit nack, input bit glitch,
                           input int abort_fall, output logic [10:0] rx);
    rx = '0;
    repeat (20) @(negedge CLOCK_50);
    rx[0] = ps2_dat_in;
    for (int i = 1; i <= 10; i++) begin
      dev_clk_low = 1'b1;
      if (i == abort_fall) begin
        repeat (half / 2) @(negedge CLOCK_50);
        return;
      end
      repeat (half) @(negedge CLOCK_50);
      rx[i] = ps2_dat_in;
      dev_clk_low = 1'b0;
      repeat (5) @(negedge CLOCK_50);
      if (i == 10 && !nack) dev_dat_low = 1'b1;
      if (glitch) begin
        repeat (half / 2 - 5) @(negedge CLOCK_50);
        dev_clk_low = 1'b1;
        repeat (3) @(negedge CLOCK_50);
        dev_clk_low = 1'b0;
        repeat (half - half / 2 - 3) @(negedge CLOCK_50);
      end else begin
        repeat (half - 5) @(negedge CLOCK_50);
      end
    end
  endtask

  task automatic finish_frame(input int half, input bit nack);
    int n;
    dev_clk_low = 1'b1;
    if (!nack) begin
      repeat (half) @(negedge CLOCK_50);
      dev_clk_low = 1'b0;
      repeat (5) @(negedge CLOCK_50);
      dev_dat_low = 1'b0;
    end
    n = 0;
    while (!(tx_done || tx_error) && n < half + 200) begin
      @(negedge CLOCK_50);
      n++;
    end
    check_eq("pulse_done", 32'(tx_done), 32'(!nack));
    check_eq("pulse_error", 32'(tx_error), 32'(nack));
    check_eq("ready_low_in_pulse", 32'(tx_ready), 32'd0);
    check_eq("lines_released", 32'({ps2_clk_oe, ps2_dat_oe}), 32'd0);
    @(negedge CLOCK_50);
    check_eq("ready_after_pulse", 32'(tx_ready), 32'd1);
    check_eq("pulse_one_cycle", 32'({tx_done, tx_error}), 32'd0);
    dev_clk_low = 1'b0;
    dev_dat_low = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit nack, input bit glitch, input bit poke);
    logic [10:0] rx;
    int half, d0, e0, reissue;
    half = int'($urandom_range(30, 60));
    d0 = done_cnt;
    e0 = err_cnt;
    start_request(b);
    if (poke) begin
      tx_data  = ~b;
      tx_valid = 1'b1;
      @(negedge CLOCK_50);
      tx_valid = 1'b0;
      tx_data  = b;
    end
    dev_frame(half, nack, glitch, 0, rx);
    finish_frame(half, nack);
    check_eq("start_bit", 32'(rx[0]), 32'd0);
    check_eq("data_byte", 32'(rx[8:1]), 32'(b));
    check_eq("parity_bit", 32'(rx[9]), 32'(ref_parity(b)));
    check_eq("stop_bit", 32'(rx[10]), 32'd1);
    repeat (2) @(negedge CLOCK_50);
    check_eq("done_count", 32'(done_cnt - d0), nack ? 32'd0 : 32'd1);
    check_eq("error_count", 32'(err_cnt - e0), nack ? 32'd1 : 32'd0);
    if (poke) begin
      reissue = 0;
      repeat (60) begin
        @(negedge CLOCK_50);
        if (ps2_clk_oe) reissue++;
      end
      check_eq("busy_request_dropped", 32'(reissue), 32'd0);
    end
  endtask

  task automatic timeout_test(input logic [7:0] b);
    int n, d0, e0;
    d0 = done_cnt;
    e0 = err_cnt;
    start_request(b);
    n = 0;
    while (!tx_error && n < TOUT + 100) begin
      @(negedge CLOCK_50);
      n++;
    end
    check_eq("timeout_cycles", 32'(n), 32'(TOUT));
    check_eq("timeout_lines_released", 32'({ps2_clk_oe, ps2_dat_oe}), 32'd0);
    @(negedge CLOCK_50);
    check_eq("timeout_ready_after", 32'(tx_ready), 32'd1);
    repeat (2) @(negedge CLOCK_50);
    check_eq("timeout_done_count", 32'(done_cnt - d0), 32'd0);
    check_eq("timeout_error_count", 32'(err_cnt - e0), 32'd1);
  endtask

  task automatic reset_mid_send(input logic [7:0] b);
    logic [10:0] rx;
    int d0, e0;
    d0 = done_cnt;
    e0 = err_cnt;
    start_request(b);
    dev_frame(40, 1'b0, 1'b0, 4, rx);
    check_eq("partial_bits", 32'(rx[3:1]), 32'(b[2:0]));
    reset = 1'b1;
    @(negedge CLOCK_50);
    reset = 1'b0;
    check_eq("reset_lines_released", 32'({ps2_clk_oe, ps2_dat_oe}), 32'd0);
    check_eq("reset_ready", 32'(tx_ready), 32'd1);
    check_eq("reset_busy", 32'(busy), 32'd0);
    dev_clk_low = 1'b0;
    dev_dat_low = 1'b0;
    repeat (50) @(negedge CLOCK_50);
    check_eq("reset_no_done", 32'(done_cnt - d0), 32'd0);
    check_eq("reset_no_error", 32'(err_cnt - e0), 32'd0);
    check_eq("reset_stays_idle", 32'(tx_ready), 32'd1);
  endtask

  initial begin
    repeat (3) @(negedge CLOCK_50);
    check_eq("rst_ready", 32'(tx_ready), 32'd1);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_pulses", 32'({tx_done, tx_error}), 32'd0);
    check_eq("rst_oe", 32'({ps2_clk_oe, ps2_dat_oe}), 32'd0);
    reset = 1'b0;
    @(negedge CLOCK_50);

    send_byte(8'hED, 1'b0, 1'b0, 1'b0);
    send_byte(8'hFF, 1'b0, 1'b0, 1'b0);
    send_byte(8'hA6, 1'b1, 1'b0, 1'b0);
    timeout_test(8'h3C);
    reset_mid_send(8'hED);
    send_byte(8'hF4, 1'b0, 1'b0, 1'b0);
    send_byte(8'h55, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) begin
      send_byte(8'($urandom_range(0, 255)), ($urandom_range(0, 3) == 0),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_600_000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
